path_stack: RTL and testbench

PATH_STACK -- requirements
Module: path_stack

---
 rtl/path_stack_if.sv | 34 +++
 rtl/path_stack.sv | 142 ++++++++++++++
 tb/tb_path_stack.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/path_stack_if.sv
// path_stack_if: bundle of the path stack's command, status and replay-stream
// signals.
//   master : drives push/pop/dirIn/replay/outReady, observes status and stream
//   slave  : the stack itself; receives the commands, drives status and stream
interface path_stack_if #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned DW    = 2
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic          push;
  logic          pop;
  logic [DW-1:0] dirIn;
  logic          replay;
  logic          outReady;
  logic [DW-1:0] topDir;
  logic          empStck;
  logic          full;
  logic [CW-1:0] count;
  logic [DW-1:0] dirOut;
  logic          outValid;
  logic          replayDone;
  logic          overflow;

  modport master (
    output push, pop, dirIn, replay, outReady,
    input  topDir, empStck, full, count, dirOut, outValid, replayDone, overflow
  );

  modport slave (
    input  push, pop, dirIn, replay, outReady,
    output topDir, empStck, full, count, dirOut, outValid, replayDone, overflow
  );
endinterface

// File: rtl/path_stack.sv
// path_stack: LIFO of direction codes that can also stream its whole contents
// out oldest-first under a valid/ready handshake, then empties itself.
// Ports:
//   clk  : clock, all state changes on the rising edge
//   rst  : asynchronous active-low reset
//   bus  : path_stack_if.slave
//          push/pop/dirIn     stack commands (RUN state only)
//          replay             request to stream contents bottom-first
//          outReady           consumer accepts dirOut
//          topDir/empStck/full/count  status of the stored stack
//          dirOut/outValid    replay stream
//          replayDone         one-cycle pulse when the stream has finished
//          overflow           sticky, set by a push while full
module path_stack #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned DW    = 2
) (
  input  logic         clk,
  input  logic         rst,
  path_stack_if.slave  bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    REPLAY = 2'd1,
    FINISH = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] read_idx_q, read_idx_d;
  logic          overflow_q, overflow_d;

  logic [DW-1:0] mem_q [DEPTH];
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;

  logic [CW-1:0] count_m1;
  logic          is_empty;
  logic          is_full;
  logic          last_word;

  // Status decode from the registered count
  assign count_m1  = count_q - CW'(1);
  assign is_empty  = (count_q == '0);
  assign is_full   = (count_q == CW'(DEPTH));
  assign last_word = ({1'b0, read_idx_q} == count_m1);

  // Next-state, memory write and counter logic
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    read_idx_d = read_idx_q;
    overflow_d = overflow_q;
    mem_we     = 1'b0;
    mem_waddr  = AW'(count_q);
    mem_wdata  = bus.dirIn;

    unique case (state_q)
      RUN: begin
        if (bus.push && bus.pop && !is_empty) begin
          // Replace the top entry in place
          mem_we    = 1'b1;
          mem_waddr = AW'(count_m1);
        end else if (bus.push) begin
          if (!is_full) begin
            mem_we    = 1'b1;
            mem_waddr = AW'(count_q);
            count_d   = count_q + CW'(1);
          end else begin
            overflow_d = 1'b1;
          end
        end else if (bus.pop && !is_empty) begin
          count_d = count_m1;
        end

        // Replay looks at the count after this cycle's push/pop
        if (bus.replay) begin
          read_idx_d = '0;
          state_d    = (count_d != '0) ? REPLAY : FINISH;
        end
      end

      REPLAY: begin
        if (bus.outReady) begin
          if (last_word) begin
            state_d = FINISH;
          end else begin
            read_idx_d = read_idx_q + AW'(1);
          end
        end
      end

      FINISH: begin
        count_d    = '0;
        read_idx_d = '0;
        state_d    = RUN;
      end

      default: begin
        state_d = RUN;
      end
    endcase
  end

  // Control state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= RUN;
      count_q    <= '0;
      read_idx_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      read_idx_q <= read_idx_d;
      overflow_q <= overflow_d;
    end
  end

  // Entry storage; contents are unobservable while count is 0, so no reset
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  // Outputs are decodes of registered state only
  assign bus.topDir     = is_empty ? '0 : mem_q[AW'(count_m1)];
  assign bus.empStck    = is_empty;
  assign bus.full       = is_full;
  assign bus.count      = count_q;
  assign bus.overflow   = overflow_q;
  assign bus.outValid   = (state_q == REPLAY);
  assign bus.dirOut     = (state_q == REPLAY) ? mem_q[read_idx_q] : '0;
  assign bus.replayDone = (state_q == FINISH);

endmodule

// File: tb/tb_path_stack.sv
// tb_path_stack: scenario tasks for path_stack (DEPTH=4) with a reference
// stack model; replay words are queued when replay is requested and compared
// as the DUT hands them over.
module tb_path_stack;

  localparam int DEPTH = 4;
  localparam int DW    = 2;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic clk;
  logic rst;

  path_stack_if #(.DEPTH(DEPTH), .DW(DW)) bus ();

  path_stack #(.DEPTH(DEPTH), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mdl [DEPTH];
  int            mcount = 0;
  logic [DW-1:0] exp_q [$];

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One RUN-state command cycle; the model follows the stack rules
  task automatic op(input bit p, input bit q, input logic [DW-1:0] d, input bit rp);
    bus.push = p; bus.pop = q; bus.dirIn = d; bus.replay = rp;
    step();
    bus.push = 1'b0; bus.pop = 1'b0; bus.replay = 1'b0;
    if (p && q && mcount > 0) mdl[mcount-1] = d;
    else if (p) begin
      if (mcount < DEPTH) begin mdl[mcount] = d; mcount++; end
    end else if (q && mcount > 0) mcount--;
    if (rp) for (int i = 0; i < mcount; i++) exp_q.push_back(mdl[i]);
  endtask

  // Consume a replay stream with a per-cycle ready pattern (bit c = cycle c)
  task automatic drain(input logic [15:0] rdy, input string tag, output int nvalid);
    int dones;
    bit stall;
    logic [DW-1:0] held;
    logic [DW-1:0] e;
    dones = 0; stall = 1'b0; held = '0; nvalid = 0;
    for (int c = 0; c < 40 && dones == 0; c++) begin
      bus.outReady = rdy[c % 16];
      #1;
      if (stall) begin
        checks++; if (bus.outValid !== 1'b1 || bus.dirOut !== held) begin errors++; $display("FAIL %s stall_hold got valid=%b dir=%0d want valid=1 dir=%0d", tag, bus.outValid, bus.dirOut, held); end
      end
      if (bus.replayDone === 1'b1) begin
        dones++;
        checks++; if (bus.outValid !== 1'b0 || exp_q.size() != 0) begin errors++; $display("FAIL %s done_state got valid=%b left=%0d want valid=0 left=0", tag, bus.outValid, exp_q.size()); end
      end else if (bus.outValid === 1'b1 && bus.outReady === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL %s extra_word got %0d want none", tag, bus.dirOut); end
        else begin
          e = exp_q.pop_front();
          if (bus.dirOut !== e) begin errors++; $display("FAIL %s word got %0d want %0d", tag, bus.dirOut, e); end
        end
      end
      if (bus.outValid === 1'b1) nvalid++;
      stall = (bus.outValid === 1'b1) && (bus.outReady === 1'b0);
      held  = bus.dirOut;
      step();
    end
    bus.outReady = 1'b0;
    checks++; if (dones != 1) begin errors++; $display("FAIL %s timeout got dones=%0d want 1", tag, dones); end
    checks++; if (bus.replayDone !== 1'b0) begin errors++; $display("FAIL %s done_width got %b want 0", tag, bus.replayDone); end
    checks++; if (bus.count !== CW'(0)) begin errors++; $display("FAIL %s count_after got %0d want 0", tag, bus.count); end
    mcount = 0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.push = 1'b0; bus.pop = 1'b0; bus.dirIn = '0; bus.replay = 1'b0; bus.outReady = 1'b0;
    #23;
    checks++; if (bus.count !== CW'(0)) begin errors++; $display("FAIL reset_count got %0d want 0", bus.count); end
    checks++; if (bus.empStck !== 1'b1) begin errors++; $display("FAIL reset_empty got %b want 1", bus.empStck); end
    checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", bus.full); end
    checks++; if (bus.topDir !== 2'd0) begin errors++; $display("FAIL reset_top got %0d want 0", bus.topDir); end
    checks++; if (bus.outValid !== 1'b0 || bus.dirOut !== 2'd0) begin errors++; $display("FAIL reset_stream got valid=%b dir=%0d want 0 0", bus.outValid, bus.dirOut); end
    checks++; if (bus.replayDone !== 1'b0 || bus.overflow !== 1'b0) begin errors++; $display("FAIL reset_flags got done=%b ovf=%b want 0 0", bus.replayDone, bus.overflow); end
    @(negedge clk);
    rst = 1'b1;
    mcount = 0;
  endtask

  task automatic test_push();
    op(1, 0, 2'd1, 0);
    op(1, 0, 2'd2, 0);
    op(1, 0, 2'd3, 0);
    checks++; if (bus.count !== CW'(3)) begin errors++; $display("FAIL push_count got %0d want 3", bus.count); end
    checks++; if (bus.topDir !== 2'd3) begin errors++; $display("FAIL push_top got %0d want 3", bus.topDir); end
    checks++; if (bus.empStck !== 1'b0) begin errors++; $display("FAIL push_empty got %b want 0", bus.empStck); end
  endtask

  task automatic test_pop_overwrite();
    int nv;
    op(0, 1, 2'd0, 0);
    checks++; if (bus.topDir !== 2'd2) begin errors++; $display("FAIL pop_top got %0d want 2", bus.topDir); end
    op(1, 1, 2'd0, 0);
    checks++; if (bus.count !== CW'(2)) begin errors++; $display("FAIL ovw_count got %0d want 2", bus.count); end
    checks++; if (bus.topDir !== 2'd0) begin errors++; $display("FAIL ovw_top got %0d want 0", bus.topDir); end
    op(0, 0, 2'd0, 1);
    drain(16'hFFFF, "ovw_replay", nv);
  endtask

  task automatic test_full_overflow();
    op(1, 0, 2'd1, 0);
    op(1, 0, 2'd2, 0);
    op(1, 0, 2'd3, 0);
    checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL full_early got %b want 0", bus.full); end
    op(1, 0, 2'd0, 0);
    checks++; if (bus.full !== 1'b1 || bus.overflow !== 1'b0) begin errors++; $display("FAIL full_4th got full=%b ovf=%b want 1 0", bus.full, bus.overflow); end
    op(1, 0, 2'd2, 0);
    checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %b want 1", bus.overflow); end
    checks++; if (bus.count !== CW'(4) || bus.topDir !== 2'd0) begin errors++; $display("FAIL ovf_keep got count=%0d top=%0d want 4 0", bus.count, bus.topDir); end
    for (int i = 0; i < 5; i++) op(0, 1, 2'd0, 0);
    checks++; if (bus.count !== CW'(0) || bus.empStck !== 1'b1) begin errors++; $display("FAIL pop_empty got count=%0d empty=%b want 0 1", bus.count, bus.empStck); end
    checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", bus.overflow); end
  endtask

  task automatic test_replay_stall();
    int nv;
    op(1, 0, 2'd2, 0);
    op(1, 0, 2'd0, 0);
    op(1, 0, 2'd3, 0);
    op(1, 0, 2'd1, 0);
    op(0, 0, 2'd0, 1);
    checks++; if (exp_q.size() != 4) begin errors++; $display("FAIL stall_queue got %0d want 4", exp_q.size()); end
    drain(16'hFFFD, "stall_replay", nv);
    checks++; if (nv != 5) begin errors++; $display("FAIL stall_valid_cycles got %0d want 5", nv); end
  endtask

  task automatic test_replay_empty();
    int nv;
    op(0, 0, 2'd0, 1);
    checks++; if (bus.replayDone !== 1'b1) begin errors++; $display("FAIL empty_done got %b want 1", bus.replayDone); end
    drain(16'hFFFF, "empty_replay", nv);
    checks++; if (nv != 0) begin errors++; $display("FAIL empty_valid got %0d want 0", nv); end
  endtask

  task automatic test_replay_with_cmd();
    int nv;
    op(1, 0, 2'd3, 0);
    op(1, 0, 2'd1, 1);
    drain(16'hFFFF, "push_replay", nv);
    checks++; if (nv != 2) begin errors++; $display("FAIL push_replay_len got %0d want 2", nv); end
    op(1, 0, 2'd2, 0);
    op(1, 1, 2'd0, 1);
    drain(16'hFFFF, "ovw_same_replay", nv);
    checks++; if (nv != 1) begin errors++; $display("FAIL ovw_replay_len got %0d want 1", nv); end
  endtask

  task automatic test_reset_mid_replay();
    op(1, 0, 2'd1, 0);
    op(1, 0, 2'd2, 0);
    op(1, 0, 2'd3, 0);
    op(0, 0, 2'd0, 1);
    bus.outReady = 1'b1;
    checks++; if (bus.outValid !== 1'b1 || bus.dirOut !== 2'd1) begin errors++; $display("FAIL abort_w1 got valid=%b dir=%0d want 1 1", bus.outValid, bus.dirOut); end
    step();
    checks++; if (bus.outValid !== 1'b1 || bus.dirOut !== 2'd2) begin errors++; $display("FAIL abort_w2 got valid=%b dir=%0d want 1 2", bus.outValid, bus.dirOut); end
    #2 rst = 1'b0;
    #1;
    checks++; if (bus.outValid !== 1'b0 || bus.count !== CW'(0)) begin errors++; $display("FAIL abort_now got valid=%b count=%0d want 0 0", bus.outValid, bus.count); end
    step();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (bus.replayDone !== 1'b0 || bus.outValid !== 1'b0) begin errors++; $display("FAIL abort_quiet got done=%b valid=%b want 0 0", bus.replayDone, bus.outValid); end
      step();
    end
    bus.outReady = 1'b0;
    mcount = 0;
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_push();
    test_pop_overwrite();
    test_full_overflow();
    test_replay_stall();
    test_replay_empty();
    test_replay_with_cmd();
    test_reset_mid_replay();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
